// File: rtl/uart_pkg.sv
// Shared UART definitions (state encoding, framing constants, baud divisor).
// UART_TX_PARITY_EN adds the PARITY state to the encoding.
package uart_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  // Clocks per bit; the receive side derives its sampling from the same value.
  function automatic int div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Byte FIFO for the UART transmitter: synchronous write, flags from registered count.
// Latency: pushed data visible on rdata the cycle after the push; push refused while full.
module tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed by a byte FIFO; UART_TX_PARITY_EN inserts an even parity bit.
// tx falls one edge after the acceptance edge; tx_rd drops while the FIFO is full.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  output logic       tx,
  input  logic       tx_ready,
  output logic       tx_rd,
  input  logic [7:0] tx_data,
  output logic       busy
);
  localparam int             DIV     = div(CLK_FREQ, BAUD);
  localparam int             CW      = $clog2(DIV);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DIV - 1);
  localparam int             AW      = $clog2(FIFO_DEPTH);

  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [AW:0]   fifo_count;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          bit_end, load;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  assign tx_rd   = tx_ready && !fifo_full && !rst;
  assign tx      = tx_q;
  assign busy    = (state_q != IDLE) || (fifo_count != '0);
  assign bit_end = (cnt_q == CNT_MAX);

  tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_rd),
    .wdata (tx_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    load     = 1'b0;
    fifo_pop = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif
    if (state_q != IDLE) cnt_d = bit_end ? '0 : cnt_q + CW'(1);

    case (state_q)
      IDLE:  load = !fifo_empty;
      START: if (bit_end) begin
        state_d = DATA;
        idx_d   = '0;
        tx_d    = shift_q[0];
      end
      DATA: if (bit_end) begin
        if (idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
          tx_d    = par_q;
`else
          state_d = STOP;
          tx_d    = STOP_BIT;
`endif
        end else begin
          idx_d   = idx_q + 3'd1;
          shift_d = {1'b0, shift_q[7:1]};
          tx_d    = shift_q[1];
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) begin
        state_d = STOP;
        tx_d    = STOP_BIT;
      end
`endif
      // Chaining straight into the next START keeps back-to-back frames gap-free.
      STOP: if (bit_end) begin
        if (!fifo_empty) load = 1'b1;
        else             state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      fifo_pop = 1'b1;
      shift_d  = fifo_rdata;
      state_d  = START;
      tx_d     = START_BIT;
      cnt_d    = '0;
`ifdef UART_TX_PARITY_EN
      par_d    = ^fifo_rdata;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= STOP_BIT;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: vector table, scoreboard frame monitor, corner-case sequences.
module tb_uart_tx;
  localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int NS = NB * DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx;
  logic       tx_ready;
  logic       tx_rd;
  logic [7:0] tx_data;
  logic       busy;

  uart_tx #(.CLK_FREQ(4), .BAUD(1), .FIFO_DEPTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx       (tx),
    .tx_ready (tx_ready),
    .tx_rd    (tx_rd),
    .tx_data  (tx_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         n_frames = 0;
  int         last_start = 0;
  int         prev_start = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_rx_data;
  logic       last_rx_par;

  typedef struct {
    logic [7:0] data;
    logic       exp_par;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected line samples for one whole frame, DIV samples per bit.
  function automatic logic [NS-1:0] frame_of(input logic [7:0] d);
    logic [NS-1:0] f;
    logic          b;
    f = '0;
    for (int k = 0; k < NB; k++) begin
      if (k == 0)                  b = 1'b0;
      else if (k <= 8)             b = d[k-1];
      else if (NB == 11 && k == 9) b = ^d;
      else                         b = 1'b1;
      for (int j = 0; j < DIV; j++) f[k*DIV+j] = b;
    end
    return f;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Scoreboard: bytes queued when accepted, popped when a full frame has been seen on tx.
  initial begin : monitor
    logic [NS-1:0] cap;
    int            cap_n;
    bit            capturing;
    logic [7:0]    d;
    cap = '0;
    cap_n = 0;
    capturing = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        capturing = 1'b0;
      end else begin
        if (tx_rd) exp_q.push_back(tx_data);
        if (!capturing && tx == 1'b0) begin
          capturing  = 1'b1;
          cap_n      = 0;
          prev_start = last_start;
          last_start = cyc;
        end
        if (capturing) begin
          cap[cap_n] = tx;
          cap_n++;
          if (cap_n == NS) begin
            capturing = 1'b0;
            n_frames++;
            for (int i = 0; i < 8; i++) last_rx_data[i] = cap[(i+1)*DIV + DIV/2];
            last_rx_par = cap[9*DIV + DIV/2];
            if (exp_q.size() == 0) begin
              chk("frame_unexpected", 64'd1, 64'd0);
            end else begin
              d = exp_q.pop_front();
              chk("frame_bits", 64'(cap), 64'(frame_of(d)));
            end
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, output bit ok);
    tx_data  = d;
    tx_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_rd) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
  endtask

  task automatic wait_idle(input int lim, output int n);
    n = 0;
    for (int i = 0; i < lim; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (!busy) break;
    end
  endtask

  initial begin : stim
    bit         ok;
    bit         found;
    bit         acc;
    int         n;
    int         f0;
    int         acc_cnt;
    logic [7:0] d;
    logic       ptx;

    vecs[0] = '{8'h3E, 1'b1};
    vecs[1] = '{8'h03, 1'b0};
    vecs[2] = '{8'h00, 1'b0};
    vecs[3] = '{8'hFF, 1'b0};
    vecs[4] = '{8'h80, 1'b1};
    vecs[5] = '{8'h41, 1'b0};

    rst = 1'b1;
    tx_ready = 1'b1;
    tx_data = 8'h5A;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 64'(tx), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_tx_rd", 64'(tx_rd), 64'd0);
    tx_ready = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_tx", 64'(tx), 64'd1);

    // Single frames from idle.
    for (int v = 0; v < 6; v++) begin
      f0 = n_frames;
      send_byte(vecs[v].data, ok);
      chk("accept", 64'(ok), 64'd1);
      chk("tx_hold_on_accept", 64'(tx), 64'd1);
      chk("busy_queued", 64'(busy), 64'd1);
      @(posedge clk);
      #1;
      chk("tx_start_edge", 64'(tx), 64'd0);
      wait_idle(200, n);
      chk("frame_len", 64'(n), 64'(NS));
      chk("frame_count", 64'(n_frames - f0), 64'd1);
      chk("rx_data", 64'(last_rx_data), 64'(vecs[v].data));
`ifdef UART_TX_PARITY_EN
      chk("rx_parity", 64'(last_rx_par), 64'(vecs[v].exp_par));
`endif
      repeat (3) @(posedge clk);
      #1;
    end

    // Back-to-back bytes: frames must abut with no idle gap.
    f0 = n_frames;
    tx_data = 8'h55;
    tx_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_rd) begin
        found = 1'b1;
        break;
      end
    end
    chk("b2b_accept1", 64'(found), 64'd1);
    @(posedge clk);
    #1;
    tx_data = 8'hAA;
    @(negedge clk);
    chk("b2b_accept2", 64'(tx_rd), 64'd1);
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    wait_idle(3 * NS, n);
    chk("b2b_frames", 64'(n_frames - f0), 64'd2);
    chk("b2b_gap", 64'(last_start - prev_start), 64'(NS));
    chk("b2b_last", 64'(last_rx_data), 64'hAA);
    repeat (3) @(posedge clk);
    #1;

    // Burst: tx_ready held 20 cycles fills the FIFO after 17 accepts.
    f0 = n_frames;
    acc_cnt = 0;
    d = 8'h20;
    tx_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tx_data = d;
      @(negedge clk);
      acc = tx_rd;
      if (acc) acc_cnt++;
      @(posedge clk);
      #1;
      if (acc) d = d + 8'd1;
    end
    chk("burst_accepts", 64'(acc_cnt), 64'd17);

    // Still full: the push on the pop edge is refused, accepted the cycle after.
    tx_data = d;
    ptx = tx;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_rd) begin
        found = 1'b1;
        break;
      end
      ptx = tx;
    end
    chk("refill_found", 64'(found), 64'd1);
    chk("refill_after_pop", 64'({ptx, tx}), 64'b10);
    @(posedge clk);
    #1;
    d = d + 8'd1;
    tx_data = d;
    @(negedge clk);
    chk("refull", 64'(tx_rd), 64'd0);
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    wait_idle(18 * NS + 100, n);
    chk("burst_idle", 64'(busy), 64'd0);
    chk("burst_frames", 64'(n_frames - f0), 64'd18);
    chk("burst_sb_empty", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;

    // Reset two bit-times into a frame aborts it; the next byte goes out clean.
    send_byte(8'h00, ok);
    chk("abort_accept", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    chk("abort_started", 64'(tx), 64'd0);
    repeat (2 * DIV - 1) @(posedge clk);
    #1;
    f0 = n_frames;
    rst = 1'b1;
    #1;
    chk("abort_tx_high", 64'(tx), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_resume", 64'(tx), 64'd1);
    chk("abort_no_frame", 64'(n_frames - f0), 64'd0);
    send_byte(8'h41, ok);
    wait_idle(200, n);
    chk("after_abort_len", 64'(n), 64'(NS + 1));
    chk("after_abort_frames", 64'(n_frames - f0), 64'd1);
    chk("after_abort_data", 64'(last_rx_data), 64'h41);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
